cpu_top: RTL and testbench
==========================

# cpu_top

Single-cycle RV32I-subset processor core with internal instruction memory, register file and data memory. Every instruction fetches, decodes, executes, accesses memory and writes back in one clock cycle. Top-level block of the CPU; its only ports are clock and reset, and the bench observes and loads it through fixed hierarchical names.

## Interface
- IMEM_WORDS, 64: instruction memory depth in 32-bit words.
- DMEM_WORDS, 64: data memory depth in 32-bit words.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Required hierarchy, accessed by the bench and not renamable:
  - pc: 32-bit byte address.
  - instr: 32-bit current instruction.
  - instr_mem.INSTR_MEM[]: 32-bit word array.
  - regfile_inst.REGISTER_FILE[0:31]: 32-bit registers.
  - data_mem_inst.DATA_MEMORY[]: 32-bit word array.

## Operation
- Fetch: instr = INSTR_MEM[pc[31:2] mod IMEM_WORDS], combinational.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - I-type: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - Memory: lw, sw.
  - Branch: beq, bne.
- Immediates are sign-extended to 32 bits. Shift amounts use the low 5 bits.
- slt/slti compare signed; sltu/sltiu compare unsigned. Result is 1 or 0.
- lw/sw: word address = (rs1 + imm)[31:2] mod DMEM_WORDS. Low two address bits are ignored; no misalignment trap.
- Branch target = pc + sign-extended B-immediate. Taken when the condition holds; otherwise pc + 4.
- x0 reads 0 always; writes to x0 are discarded.
- Any unsupported or illegal encoding, including 32'h00000000, is a nop: pc + 4, no register or memory write.
- Register file reads are combinational, writes are synchronous. A same-cycle read of the register being written returns the old value.
- All arithmetic is 32-bit wraparound; no overflow detection.

## Timing
- Reset asserted, immediately and asynchronously:
  - pc = 0.
  - REGISTER_FILE[0..31] = 0.
- Reset does not touch INSTR_MEM or DATA_MEMORY, so the bench may load programs during or after reset.
- INSTR_MEM and DATA_MEMORY are zero-initialised at time zero.
- One instruction retires per rising clk edge while reset is low. The pc, register write and memory write for that instruction all commit on that edge.
- Load latency is 0: lw data is written to rd on the same edge that retires the lw.
- A sw followed by lw in the next cycle returns the stored value.
- Reset asserted mid-program: pc returns to 0 and registers clear at once. Execution restarts on the first edge after release.
- PC wrap: fetch index wraps modulo IMEM_WORDS; pc itself is a plain 32-bit register.

## Configuration
- CPU_JUMP_EN:
  - Defined: jal and jalr are implemented. rd = pc + 4. Targets are pc + J-immediate, and (rs1 + imm) & ~1 respectively.
  - Undefined: both opcodes decode as nops.

## Test plan
- ALU and immediates. Program from pc 0: addi x1,x0,7; addi x2,x0,8; add x3,x1,x2; sub x4,x2,x1; andi x5,x1,3; ori x6,x1,4; xori x7,x1,2; slti x8,x1,8.
  - After 8 edges: x1=7, x2=8, x3=15, x4=1, x5=3, x6=7, x7=5, x8=1.
- Memory. Continue with sw x3,0(x0); lw x9,0(x0).
  - DATA_MEMORY[0]=15 after the sw edge; x9=15 after the lw edge.
- Branch taken. Continue with beq x3,x9,+8 at pc 40.
  - Next pc=48 (pc 44 skipped). Then pc advances by 4 through zero words (nops) with no register change for the remaining cycles.
- Branch not taken and x0. bne x0,x0,+8 gives pc+4. addi x0,x0,5 leaves x0=0.
- Reset mid-run. Assert reset between edges.
  - pc=0 and all registers 0 immediately, with no clock edge needed. INSTR_MEM is intact and the program re-executes after release.
- Signed vs unsigned compare and shifts:
  - addi x10,x0,-1; slt x11,x10,x0 → x11=1; sltu x12,x10,x0 → x12=0.
  - srai x13,x10,4 → 0xFFFFFFFF; srli x14,x10,28 → 0xF.

Source files
------------

// File: rtl/cpu_top.sv
// Single-cycle RV32I-subset core with internal instruction memory, register file and data memory.
// Optional jal/jalr support is enabled by defining CPU_JUMP_EN; memory depths must be powers of two.

module InstrMem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   data_o
);
  logic [31:0] INSTR_MEM [0:WORDS-1] = '{default: '0};

  assign data_o = INSTR_MEM[addr_i];
endmodule

module RegFile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] REGISTER_FILE [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) REGISTER_FILE[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      REGISTER_FILE[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : REGISTER_FILE[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : REGISTER_FILE[raddr2_i];
endmodule

module DataMem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] DATA_MEMORY [0:WORDS-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) DATA_MEMORY[addr_i] <= wdata_i;
  end

  assign rdata_o = DATA_MEMORY[addr_i];
endmodule

module cpu_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef CPU_JUMP_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } aluOp_e;

  logic [31:0] pc, pc_d, instr;
  logic [31:0] rs1Val, rs2Val, rdVal, memAddr, loadData;
  logic        regWe, memWe;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] immI, immS, immB;

  function automatic logic [31:0] alu(input aluOp_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      default:  return a + b;
    endcase
  endfunction

  InstrMem #(.WORDS(IMEM_WORDS)) instr_mem (
    .addr_i (IA'(pc >> 2)),
    .data_o (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign immI   = {{20{instr[31]}}, instr[31:20]};
  assign immS   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
`ifdef CPU_JUMP_EN
  logic [31:0] immJ;
  assign immJ   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`endif

  RegFile regfile_inst (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1Val),
    .rdata2_o (rs2Val),
    .we_i     (regWe),
    .waddr_i  (rd),
    .wdata_i  (rdVal)
  );

  DataMem #(.WORDS(DMEM_WORDS)) data_mem_inst (
    .clk     (clk),
    .we_i    (memWe),
    .addr_i  (DA'(memAddr >> 2)),
    .wdata_i (rs2Val),
    .rdata_o (loadData)
  );

  // Anything not explicitly decoded below falls through as a nop.
  always_comb begin
    pc_d    = pc + 32'd4;
    regWe   = 1'b0;
    memWe   = 1'b0;
    rdVal   = '0;
    memAddr = rs1Val + immI;
    case (opcode)
      OP_R: begin
        regWe = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: rdVal = alu(ALU_ADD,  rs1Val, rs2Val);
          10'b0100000_000: rdVal = alu(ALU_SUB,  rs1Val, rs2Val);
          10'b0000000_111: rdVal = alu(ALU_AND,  rs1Val, rs2Val);
          10'b0000000_110: rdVal = alu(ALU_OR,   rs1Val, rs2Val);
          10'b0000000_100: rdVal = alu(ALU_XOR,  rs1Val, rs2Val);
          10'b0000000_010: rdVal = alu(ALU_SLT,  rs1Val, rs2Val);
          10'b0000000_011: rdVal = alu(ALU_SLTU, rs1Val, rs2Val);
          10'b0000000_001: rdVal = alu(ALU_SLL,  rs1Val, rs2Val);
          10'b0000000_101: rdVal = alu(ALU_SRL,  rs1Val, rs2Val);
          10'b0100000_101: rdVal = alu(ALU_SRA,  rs1Val, rs2Val);
          default:         regWe = 1'b0;
        endcase
      end
      OP_I: begin
        regWe = 1'b1;
        case (funct3)
          3'b000: rdVal = alu(ALU_ADD,  rs1Val, immI);
          3'b010: rdVal = alu(ALU_SLT,  rs1Val, immI);
          3'b011: rdVal = alu(ALU_SLTU, rs1Val, immI);
          3'b100: rdVal = alu(ALU_XOR,  rs1Val, immI);
          3'b110: rdVal = alu(ALU_OR,   rs1Val, immI);
          3'b111: rdVal = alu(ALU_AND,  rs1Val, immI);
          3'b001: begin
            if (funct7 == 7'b0000000) rdVal = alu(ALU_SLL, rs1Val, immI);
            else                      regWe = 1'b0;
          end
          default: begin
            if (funct7 == 7'b0000000)      rdVal = alu(ALU_SRL, rs1Val, immI);
            else if (funct7 == 7'b0100000) rdVal = alu(ALU_SRA, rs1Val, immI);
            else                           regWe = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          regWe = 1'b1;
          rdVal = loadData;
        end
      end
      OP_STORE: begin
        memAddr = rs1Val + immS;
        memWe   = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        if ((funct3 == 3'b000 && rs1Val == rs2Val) || (funct3 == 3'b001 && rs1Val != rs2Val))
          pc_d = pc + immB;
      end
`ifdef CPU_JUMP_EN
      OP_JAL: begin
        regWe = 1'b1;
        rdVal = pc + 32'd4;
        pc_d  = pc + immJ;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          regWe = 1'b1;
          rdVal = pc + 32'd4;
          pc_d  = (rs1Val + immI) & ~32'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_d;
  end
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: a symbolic instruction-level model stepped alongside the core, compared every cycle,
// plus hand-computed expectations for the directed program.
module tb_cpu_top;
  typedef enum {
    M_NOP, M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA,
    M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_SLTIU, M_SLLI, M_SRLI, M_SRAI,
    M_LW, M_SW, M_BEQ, M_BNE, M_JAL, M_JALR
  } mnem_e;

  typedef struct {
    mnem_e       op;
    int          rd;
    int          rs1;
    int          rs2;
    int          imm;
    logic [31:0] raw;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          failures = 0;
  bit          checkEn = 1'b0;
  instr_t      prog [64];
  logic [31:0] mRegs [32];
  logic [31:0] mDmem [64];
  logic [31:0] mPc;

  cpu_top dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(mnem_e op, int rd, int rs1, int rs2, int imm);
    instr_t x;
    x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.imm = imm; x.raw = '0;
    return x;
  endfunction

  function automatic logic [31:0] enc(instr_t x);
    logic [31:0] im;
    logic [4:0]  d, a, b;
    im = x.imm; d = 5'(x.rd); a = 5'(x.rs1); b = 5'(x.rs2);
    case (x.op)
      M_ADD:   return {7'h00, b, a, 3'b000, d, 7'b0110011};
      M_SUB:   return {7'h20, b, a, 3'b000, d, 7'b0110011};
      M_SLL:   return {7'h00, b, a, 3'b001, d, 7'b0110011};
      M_SLT:   return {7'h00, b, a, 3'b010, d, 7'b0110011};
      M_SLTU:  return {7'h00, b, a, 3'b011, d, 7'b0110011};
      M_XOR:   return {7'h00, b, a, 3'b100, d, 7'b0110011};
      M_SRL:   return {7'h00, b, a, 3'b101, d, 7'b0110011};
      M_SRA:   return {7'h20, b, a, 3'b101, d, 7'b0110011};
      M_OR:    return {7'h00, b, a, 3'b110, d, 7'b0110011};
      M_AND:   return {7'h00, b, a, 3'b111, d, 7'b0110011};
      M_ADDI:  return {im[11:0], a, 3'b000, d, 7'b0010011};
      M_SLTI:  return {im[11:0], a, 3'b010, d, 7'b0010011};
      M_SLTIU: return {im[11:0], a, 3'b011, d, 7'b0010011};
      M_XORI:  return {im[11:0], a, 3'b100, d, 7'b0010011};
      M_ORI:   return {im[11:0], a, 3'b110, d, 7'b0010011};
      M_ANDI:  return {im[11:0], a, 3'b111, d, 7'b0010011};
      M_SLLI:  return {7'h00, im[4:0], a, 3'b001, d, 7'b0010011};
      M_SRLI:  return {7'h00, im[4:0], a, 3'b101, d, 7'b0010011};
      M_SRAI:  return {7'h20, im[4:0], a, 3'b101, d, 7'b0010011};
      M_LW:    return {im[11:0], a, 3'b010, d, 7'b0000011};
      M_SW:    return {im[11:5], b, a, 3'b010, im[4:0], 7'b0100011};
      M_BEQ:   return {im[12], im[10:5], b, a, 3'b000, im[4:1], im[11], 7'b1100011};
      M_BNE:   return {im[12], im[10:5], b, a, 3'b001, im[4:1], im[11], 7'b1100011};
      M_JAL:   return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
      M_JALR:  return {im[11:0], a, 3'b000, d, 7'b1100111};
      M_ILL:   return x.raw;
      default: return 32'h0;
    endcase
  endfunction

  // Architectural model: executes the symbolic program directly, one instruction per rising edge.
  task automatic modelStep();
    instr_t      x;
    logic [31:0] a, b, imm, res, nextPc;
    bit          wr;
    x = prog[(mPc / 4) % 64];
    a = mRegs[x.rs1]; b = mRegs[x.rs2]; imm = x.imm;
    res = '0; wr = 1'b1; nextPc = mPc + 4;
    case (x.op)
      M_ADD:   res = a + b;
      M_SUB:   res = a - b;
      M_AND:   res = a & b;
      M_OR:    res = a | b;
      M_XOR:   res = a ^ b;
      M_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      M_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      M_SLL:   res = a << (b % 32);
      M_SRL:   res = a >> (b % 32);
      M_SRA:   res = $signed(a) >>> (b % 32);
      M_ADDI:  res = a + imm;
      M_ANDI:  res = a & imm;
      M_ORI:   res = a | imm;
      M_XORI:  res = a ^ imm;
      M_SLTI:  res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      M_SLTIU: res = (a < imm) ? 32'd1 : 32'd0;
      M_SLLI:  res = a << (imm % 32);
      M_SRLI:  res = a >> (imm % 32);
      M_SRAI:  res = $signed(a) >>> (imm % 32);
      M_LW:    res = mDmem[((a + imm) / 4) % 64];
      M_SW: begin
        wr = 1'b0;
        mDmem[((a + imm) / 4) % 64] = b;
      end
      M_BEQ: begin
        wr = 1'b0;
        if (a == b) nextPc = mPc + imm;
      end
      M_BNE: begin
        wr = 1'b0;
        if (a != b) nextPc = mPc + imm;
      end
`ifdef CPU_JUMP_EN
      M_JAL: begin
        res = mPc + 4;
        nextPc = mPc + imm;
      end
      M_JALR: begin
        res = mPc + 4;
        nextPc = (a + imm) & 32'hFFFF_FFFE;
      end
`endif
      default: wr = 1'b0;
    endcase
    if (wr && x.rd != 0) mRegs[x.rd] = res;
    mPc = nextPc;
  endtask

  task automatic modelReset();
    mPc = '0;
    for (int r = 0; r < 32; r++) mRegs[r] = '0;
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(int edges);
    repeat (edges) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rf(int r);
    return dut.regfile_inst.REGISTER_FILE[r];
  endfunction

  always @(posedge clk) begin
    if (!reset) modelStep();
  end

  // Full architectural comparison once per cycle, half a period after the edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pc", dut.pc, mPc);
      for (int r = 0; r < 32; r++)
        checkOutput($sformatf("x%0d", r), dut.regfile_inst.REGISTER_FILE[r], mRegs[r]);
      for (int w = 0; w < 8; w++)
        checkOutput($sformatf("dmem%0d", w), dut.data_mem_inst.DATA_MEMORY[w], mDmem[w]);
    end
  end

  initial begin
    logic [31:0] nz;
    for (int i = 0; i < 64; i++) prog[i] = mk(M_NOP, 0, 0, 0, 0);
    for (int w = 0; w < 64; w++) mDmem[w] = '0;
    prog[0]  = mk(M_ADDI, 1, 0, 0, 7);
    prog[1]  = mk(M_ADDI, 2, 0, 0, 8);
    prog[2]  = mk(M_ADD, 3, 1, 2, 0);
    prog[3]  = mk(M_SUB, 4, 2, 1, 0);
    prog[4]  = mk(M_ANDI, 5, 1, 0, 3);
    prog[5]  = mk(M_ORI, 6, 1, 0, 4);
    prog[6]  = mk(M_XORI, 7, 1, 0, 2);
    prog[7]  = mk(M_SLTI, 8, 1, 0, 8);
    prog[8]  = mk(M_SW, 0, 0, 3, 0);
    prog[9]  = mk(M_LW, 9, 0, 0, 0);
    prog[10] = mk(M_BEQ, 0, 3, 9, 8);
    prog[11] = mk(M_ADDI, 20, 0, 0, 99);
    prog[12] = mk(M_BNE, 0, 0, 0, 8);
    prog[13] = mk(M_ADDI, 0, 0, 0, 5);
    prog[14] = mk(M_ADDI, 10, 0, 0, -1);
    prog[15] = mk(M_SLT, 11, 10, 0, 0);
    prog[16] = mk(M_SLTU, 12, 10, 0, 0);
    prog[17] = mk(M_SRAI, 13, 10, 0, 4);
    prog[18] = mk(M_SRLI, 14, 10, 0, 28);
    prog[19] = mk(M_SLL, 15, 1, 2, 0);
    prog[20] = mk(M_SRL, 16, 10, 1, 0);
    prog[21] = mk(M_SRA, 17, 10, 1, 0);
    prog[22] = mk(M_XOR, 18, 3, 1, 0);
    prog[23] = mk(M_AND, 19, 3, 2, 0);
    prog[24] = mk(M_OR, 21, 1, 2, 0);
    prog[25] = mk(M_SLTIU, 22, 1, 0, -1);
    prog[26] = mk(M_SLLI, 23, 1, 0, 4);
    prog[27] = mk(M_SW, 0, 0, 23, 5);
    prog[28] = mk(M_LW, 24, 0, 0, 4);
    prog[29] = mk(M_ILL, 0, 0, 0, 0);
    prog[29].raw = 32'hFFFF_FFFF;
    prog[30] = mk(M_JAL, 25, 0, 0, 8);
    prog[31] = mk(M_ADDI, 26, 0, 0, 1);
    prog[32] = mk(M_SW, 0, 1, 2, 8);
    prog[33] = mk(M_LW, 28, 2, 0, -3);

    #1;
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 64; i++) dut.instr_mem.INSTR_MEM[i] = enc(prog[i]);
    #1;
    checkOutput("resetPc", dut.pc, 32'h0);
    checkOutput("resetX1", rf(1), 32'h0);
    checkOutput("fetchWord0", dut.instr, 32'h0070_0093);
    checkEn = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(8);
    checkOutput("aluX1", rf(1), 32'd7);
    checkOutput("aluX2", rf(2), 32'd8);
    checkOutput("aluX3", rf(3), 32'd15);
    checkOutput("aluX4", rf(4), 32'd1);
    checkOutput("aluX5", rf(5), 32'd3);
    checkOutput("aluX6", rf(6), 32'd7);
    checkOutput("aluX7", rf(7), 32'd5);
    checkOutput("aluX8", rf(8), 32'd1);
    applyStimulus(1);
    checkOutput("swDmem0", dut.data_mem_inst.DATA_MEMORY[0], 32'd15);
    applyStimulus(1);
    checkOutput("lwX9", rf(9), 32'd15);
    applyStimulus(1);
    checkOutput("beqTakenPc", dut.pc, 32'd48);
    applyStimulus(1);
    checkOutput("bneNotTakenPc", dut.pc, 32'd52);
    applyStimulus(1);
    checkOutput("x0Discard", rf(0), 32'h0);
    applyStimulus(5);
    checkOutput("addiNeg", rf(10), 32'hFFFF_FFFF);
    checkOutput("sltSigned", rf(11), 32'd1);
    checkOutput("sltuUnsigned", rf(12), 32'd0);
    checkOutput("srai", rf(13), 32'hFFFF_FFFF);
    checkOutput("srli", rf(14), 32'h0000_000F);
    applyStimulus(16);
    checkOutput("sll", rf(15), 32'h0000_0700);
    checkOutput("srl", rf(16), 32'h01FF_FFFF);
    checkOutput("sra", rf(17), 32'hFFFF_FFFF);
    checkOutput("xor", rf(18), 32'd8);
    checkOutput("and", rf(19), 32'd8);
    checkOutput("skippedX20", rf(20), 32'd0);
    checkOutput("or", rf(21), 32'd15);
    checkOutput("sltiu", rf(22), 32'd1);
    checkOutput("slli", rf(23), 32'd112);
    checkOutput("lwLowBitsIgnored", rf(24), 32'd112);
    checkOutput("swLowBitsIgnored", dut.data_mem_inst.DATA_MEMORY[1], 32'd112);
    checkOutput("swBaseOffset", dut.data_mem_inst.DATA_MEMORY[3], 32'd8);
    checkOutput("lwNegOffset", rf(28), 32'd112);

    for (int k = 0; k < 100 && mPc != 32'd256; k++) applyStimulus(1);
    checkOutput("wrapReached", mPc, 32'd256);
    checkOutput("wrapPc", dut.pc, 32'd256);
    checkOutput("wrapFetch", dut.instr, 32'h0070_0093);

    applyStimulus(5);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    nz = '0;
    for (int r = 0; r < 32; r++) if (rf(r) != 32'h0) nz++;
    checkOutput("midResetPc", dut.pc, 32'h0);
    checkOutput("midResetRegsClear", nz, 32'h0);
    checkOutput("midResetDmemKept", dut.data_mem_inst.DATA_MEMORY[0], 32'd15);
    checkOutput("midResetImemKept", dut.instr, 32'h0070_0093);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(8);
    checkOutput("rerunX1", rf(1), 32'd7);
    checkOutput("rerunX3", rf(3), 32'd15);
    checkOutput("rerunX8", rf(8), 32'd1);
    checkOutput("rerunPc", dut.pc, 32'd32);
    applyStimulus(3);
    checkOutput("rerunX9", rf(9), 32'd15);
    checkOutput("rerunBranchPc", dut.pc, 32'd48);

    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
